// File: rtl/bist_datapath.sv
// Memory BIST datapath: up/down address generator with terminal detect, memory strobes,
// and a latency-matched read checker with sticky error and first-failure capture.
module bist_datapath #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              enable,
  input  logic              rst_adr,
  input  logic              pr_res_adr,
  input  logic              up_down,
  input  logic              wr_en,
  input  logic              read_en,
  input  logic              data_bit,
  output logic              c_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              error,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  fail_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [ADDR_W-1:0] addr;
  logic [RD_LAT:1]   vld_p;
  logic              exp_p  [1:RD_LAT];
  logic [ADDR_W-1:0] addr_p [1:RD_LAT];
  logic              mismatch;

  // Terminal detect: the terminal access still happens this cycle, the register then holds.
  assign c_out     = enable & (up_down ? (addr == LAST_ADDR) : (addr == '0));
  assign mem_addr  = addr;
  assign mem_we    = enable & wr_en;
  assign mem_re    = enable & read_en;
  assign mem_wdata = {DATA_W{data_bit}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (clr || rst_adr) begin
      addr <= '0;
    end else if (pr_res_adr) begin
      addr <= LAST_ADDR;
    end else if (enable && !c_out) begin
      addr <= up_down ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
    end
  end

  // Stage 1..RD_LAT: read tags travel alongside the memory latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p[1] <= mem_re;
      for (int i = 2; i <= RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_p[1]  <= data_bit;
    addr_p[1] <= addr;
    for (int i = 2; i <= RD_LAT; i++) begin
      exp_p[i]  <= exp_p[i-1];
      addr_p[i] <= addr_p[i-1];
    end
  end

  // Stage RD_LAT: compare returned data against the expected background
  assign mismatch = vld_p[RD_LAT] & (mem_rdata != {DATA_W{exp_p[RD_LAT]}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error     <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_cnt  <= '0;
    end else if (clr) begin
      error     <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_cnt  <= '0;
    end else if (mismatch) begin
      error    <= 1'b1;
      fail_cnt <= sat_inc(fail_cnt);
      if (!error) begin
        fail_addr <= addr_p[RD_LAT];
        fail_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bist_datapath.sv
// Scoreboard bench for bist_datapath: a driver predicts per-cycle outputs from an
// abstract model of the address walk, memory contents and pending reads; a monitor compares.
module tb_bist_datapath;
  localparam int AW = 4, D = 16, D10 = 10, DW = 8, RL = 2, CW = 4;

  logic clk = 0, rst = 0, clr = 0, enable = 0, rst_adr = 0, pr_res_adr = 0;
  logic up_down = 0, wr_en = 0, read_en = 0, data_bit = 0;
  logic c_out, mem_we, mem_re, error;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, fail_data;
  logic [CW-1:0] fail_cnt;
  logic c10, we10, re10, err10;
  logic [AW-1:0] addr10, fa10;
  logic [DW-1:0] wd10, fd10, rd10;
  logic [7:0] fc10;

  assign rd10 = '0;

  bist_datapath #(.ADDR_W(AW), .DEPTH(D), .DATA_W(DW), .RD_LAT(RL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .enable(enable), .rst_adr(rst_adr),
    .pr_res_adr(pr_res_adr), .up_down(up_down), .wr_en(wr_en), .read_en(read_en),
    .data_bit(data_bit), .c_out(c_out), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .error(error),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_cnt(fail_cnt));

  bist_datapath #(.ADDR_W(AW), .DEPTH(D10), .DATA_W(DW), .RD_LAT(1), .CNT_W(8)) dut10 (
    .clk(clk), .rst(rst), .clr(clr), .enable(enable), .rst_adr(rst_adr),
    .pr_res_adr(pr_res_adr), .up_down(up_down), .wr_en(wr_en), .read_en(read_en),
    .data_bit(data_bit), .c_out(c10), .mem_addr(addr10), .mem_we(we10),
    .mem_re(re10), .mem_wdata(wd10), .mem_rdata(rd10), .error(err10),
    .fail_addr(fa10), .fail_data(fd10), .fail_cnt(fc10));

  always #5 clk = ~clk;

  // Memory environment with injectable stuck-at-1 bits and RL-cycle read latency
  logic [DW-1:0] mem_arr [0:D-1];
  logic [DW-1:0] stuck   [0:D-1];
  logic [DW-1:0] rdq     [1:RL];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    rdq[1] <= mem_arr[mem_addr] | stuck[mem_addr];
    for (int i = 2; i <= RL; i++) rdq[i] <= rdq[i-1];
  end
  assign mem_rdata = rdq[RL];

  typedef struct {
    logic c; logic [AW-1:0] a; logic we; logic re; logic [DW-1:0] wd;
    logic err; logic [AW-1:0] fa; logic [DW-1:0] fd; logic [CW-1:0] fc;
    logic c10; logic [AW-1:0] a10;
  } exp_t;
  typedef struct { int due; bit mm; logic [AW-1:0] a; logic [DW-1:0] d; } rd_t;

  exp_t sb[$];
  rd_t  pend[$];
  int   checks = 0, failures = 0;
  int   ma = 0, ma10 = 0, cyc = 0, m_fc = 0;
  bit   m_err = 0;
  logic [AW-1:0] m_fa = '0;
  logic [DW-1:0] m_fd = '0;
  logic [DW-1:0] mdl_mem [0:D-1];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("c_out",     32'(c_out),     32'(mon_e.c));
      chk("mem_addr",  32'(mem_addr),  32'(mon_e.a));
      chk("mem_we",    32'(mem_we),    32'(mon_e.we));
      chk("mem_re",    32'(mem_re),    32'(mon_e.re));
      chk("mem_wdata", 32'(mem_wdata), 32'(mon_e.wd));
      chk("error",     32'(error),     32'(mon_e.err));
      chk("fail_addr", 32'(fail_addr), 32'(mon_e.fa));
      chk("fail_data", 32'(fail_data), 32'(mon_e.fd));
      chk("fail_cnt",  32'(fail_cnt),  32'(mon_e.fc));
      chk("c_out_d10", 32'(c10),       32'(mon_e.c10));
      chk("addr_d10",  32'(addr10),    32'(mon_e.a10));
    end
  end

  task automatic step(input bit i_clr, i_ra, i_pr, i_en, i_ud, i_wr, i_rd, i_db);
    exp_t e;
    rd_t r;
    bit co, co10;
    logic [DW-1:0] rv;
    @(posedge clk); #1;
    clr = i_clr; rst_adr = i_ra; pr_res_adr = i_pr; enable = i_en;
    up_down = i_ud; wr_en = i_wr; read_en = i_rd; data_bit = i_db;
    co   = i_en && (i_ud ? (ma == D - 1)     : (ma == 0));
    co10 = i_en && (i_ud ? (ma10 == D10 - 1) : (ma10 == 0));
    e.c = co; e.a = AW'(ma); e.we = i_en & i_wr; e.re = i_en & i_rd; e.wd = {DW{i_db}};
    e.err = m_err; e.fa = m_fa; e.fd = m_fd; e.fc = CW'(m_fc);
    e.c10 = co10; e.a10 = AW'(ma10);
    sb.push_back(e);
    // what happens at the coming clock edge
    rv = mdl_mem[ma] | stuck[ma];
    if (i_clr) begin
      m_err = 0; m_fa = '0; m_fd = '0; m_fc = 0;
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.mm) begin
          if (!m_err) begin m_fa = r.a; m_fd = r.d; end
          m_err = 1;
          if (m_fc < (1 << CW) - 1) m_fc++;
        end
      end
      if (i_en && i_rd) begin
        r.due = cyc + RL; r.a = AW'(ma); r.d = rv; r.mm = (rv != {DW{i_db}});
        pend.push_back(r);
      end
    end
    if (i_en && i_wr) mdl_mem[ma] = {DW{i_db}};
    ma   = (i_clr || i_ra) ? 0 : i_pr ? D - 1   : (i_en && !co)   ? (i_ud ? ma + 1 : ma - 1)     : ma;
    ma10 = (i_clr || i_ra) ? 0 : i_pr ? D10 - 1 : (i_en && !co10) ? (i_ud ? ma10 + 1 : ma10 - 1) : ma10;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sweep(input bit ud, wr, rd, db, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, ud, wr, rd, db);
  endtask

  task automatic load(input bit up);
    step(0, up, !up, 0, up, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst = 0; clr = 0; enable = 0; rst_adr = 0; pr_res_adr = 0;
    up_down = 0; wr_en = 0; read_en = 0; data_bit = 0;
    #1;
    chk({tag, "_addr"},  32'(mem_addr),  0);
    chk({tag, "_error"}, 32'(error),     0);
    chk({tag, "_faddr"}, 32'(fail_addr), 0);
    chk({tag, "_fdata"}, 32'(fail_data), 0);
    chk({tag, "_fcnt"},  32'(fail_cnt),  0);
    chk({tag, "_cout"},  32'(c_out),     0);
    m_err = 0; m_fa = '0; m_fd = '0; m_fc = 0; ma = 0; ma10 = 0;
    pend.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic settle_chk(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b;
    for (int i = 0; i < D; i++) begin mem_arr[i] = '0; mdl_mem[i] = '0; stuck[i] = '0; end
    do_reset("init");

    // address walks on both instances
    load(1); sweep(1, 0, 0, 0, 18);
    load(0); sweep(0, 0, 0, 0, 18);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    load(1); sweep(1, 0, 0, 0, 16);

    // clean four-element March
    b = 1'($urandom_range(0, 1));
    load(1); sweep(1, 1, 0, b, 16);
    load(1); sweep(1, 0, 1, b, 16);
    load(0); sweep(0, 1, 0, !b, 16);
    load(0); sweep(0, 0, 1, !b, 16);
    idle(RL + 2);

    // stuck-at-1 bit 3 at address 6, then a second fault at address 2
    stuck[6] = 8'h08;
    load(1); sweep(1, 1, 0, 0, 16);
    load(1); sweep(1, 0, 1, 0, 16);
    idle(RL + 2);
    @(negedge clk); #1;
    chk("sa_faddr", 32'(fail_addr), 6);
    chk("sa_fdata", 32'(fail_data), 32'h08);
    chk("sa_fcnt",  32'(fail_cnt),  1);
    stuck[6] = '0; stuck[2] = 8'h08;
    load(1); sweep(1, 0, 1, 0, 16);
    idle(RL + 2);
    @(negedge clk); #1;
    chk("sa2_faddr", 32'(fail_addr), 6);
    chk("sa2_fcnt",  32'(fail_cnt),  2);
    stuck[2] = '0;

    // reset while mismatching reads are in flight
    load(0); sweep(0, 0, 1, 1, 5);
    do_reset("midrst");
    idle(RL + 3);
    @(negedge clk); #1;
    chk("midrst_stale_error", 32'(error), 0);

    // clr coincident with a mismatch
    load(1); step(0, 0, 0, 1, 1, 0, 1, 1); idle(RL + 1);
    step(0, 0, 0, 1, 1, 0, 1, 1); idle(RL - 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    @(negedge clk); #1;
    chk("clr_error", 32'(error),    0);
    chk("clr_fcnt",  32'(fail_cnt), 0);

    // randomized traffic with random faults
    for (int i = 0; i < 4; i++) stuck[$urandom_range(0, D - 1)] = DW'(1) << $urandom_range(0, DW - 1);
    for (int i = 0; i < 500; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(RL + 2);
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bist_datapath.md
Name: bist_datapath

Overview:
Address generator and response checker for the memory BIST, placed directly under the March controller. It advances the memory address up or down, signals the end of the address range (c_out) to the controller, and drives the memory write/read strobes and the background data pattern. It compares returned read data against the expected pattern and reports a sticky error together with diagnostic capture.

Parameters:
ADDR_W, 4, address width in bits
DEPTH, 16, number of words tested (2 to 2^ADDR_W; need not be a power of two)
DATA_W, 8, memory word width
RD_LAT, 1, memory read latency in cycles from mem_re sample to mem_rdata valid (1 to 4)
CNT_W, 8, width of the failure counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
clr  in  1  synchronous pulse; clears error, fail capture and pipeline (tied to controller start)
enable  in  1  counter advance enable
rst_adr  in  1  load address 0
pr_res_adr  in  1  load address DEPTH-1
up_down  in  1  1 = increment, 0 = decrement
wr_en  in  1  write phase strobe
read_en  in  1  read phase strobe
data_bit  in  1  background pattern bit
c_out  out  1  terminal address reached in the current direction
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_re
error  out  1  sticky mismatch flag
fail_addr  out  ADDR_W  address of the first mismatch
fail_data  out  DATA_W  read data of the first mismatch
fail_cnt  out  CNT_W  count of mismatching reads, saturating

Behaviour:
- Reset (rst=0, asynchronous): addr=0, error=0, fail_addr=0, fail_data=0, fail_cnt=0, all pipeline valid bits=0.
- Address register update, on each rising edge, in priority order:
  - rst_adr: load 0.
  - else pr_res_adr: load DEPTH-1.
  - else enable & ~c_out: addr+1 if up_down=1, addr-1 if up_down=0.
  - else: hold.
- rst_adr and pr_res_adr apply regardless of enable. Both asserted together: rst_adr wins.
- c_out is combinational from registers: enable & (up_down ? addr==DEPTH-1 : addr==0).
- At the terminal address the register holds; it never wraps on its own. The controller reloads it through rst_adr or pr_res_adr in the same cycle it sees c_out.
- Memory drive (combinational):
  - mem_addr=addr.
  - mem_we=enable&wr_en.
  - mem_re=enable&read_en.
  - mem_wdata={DATA_W{data_bit}}.
  - wr_en&read_en together: both strobes pass through unmodified, not checked.
- The terminal-address access is performed in the same cycle c_out is high, so every address 0..DEPTH-1 is accessed exactly once per March element.
- Check pipeline: RD_LAT-stage shift register carrying {valid=mem_re, exp=data_bit, addr}, advancing every cycle. Stage RD_LAT output is compared with mem_rdata.
- Mismatch: stage valid & (mem_rdata != {DATA_W{exp}}).
- On a mismatch:
  - error<=1.
  - fail_cnt<=fail_cnt+1, saturating at all-ones.
  - If error was 0 before this edge: fail_addr<=stage addr and fail_data<=mem_rdata. Later mismatches do not overwrite the capture.
- error is registered: it is high the cycle after the mismatch edge.
- clr (synchronous): clears error, fail_addr, fail_data, fail_cnt and all valid bits; also forces addr=0.
  - clr has priority over all other updates.
  - clr in the same cycle as a mismatch: the clear wins.
- Reads issued before reset or clr are never checked. Reset mid-test discards in-flight reads.

Test Plan:
- Up sweep, DEPTH=16: rst_adr pulse, then enable=1, up_down=1 for 16 cycles -> mem_addr 0..15; c_out high only at addr 15; addr holds at 15 on the following cycle while enable stays high.
- Down sweep after pr_res_adr -> mem_addr 15..0; c_out high only at addr 0; simultaneous rst_adr+pr_res_adr -> addr=0.
- DEPTH=10: up sweep -> c_out at addr 9, no access above 9.
- Clean March pass with RD_LAT=2 and a model memory -> error=0, fail_cnt=0 throughout all four elements.
- Stuck-at-1 on bit 3 at addr 6, data_bit=0 read -> error rises 1 cycle after rdata at cycle RD_LAT; fail_addr=6, fail_data=8'h08, fail_cnt=1.
  - Second fault at addr 2 -> fail_cnt=2, fail_addr still 6.
- rst low mid read_down with reads in flight -> all outputs are 0 immediately; after release, no stale mismatch is flagged.
- clr pulse coincident with a mismatch -> error=0, fail_cnt=0.
